uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of byte requesters (2..8).
REQ-002 Parameter TIMEOUT, default 32'd40000, SHALL set the max clk_25mhz cycles from tx_start to tx_done before abort.
REQ-003 clk_25mhz  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset_n  in  1  SHALL be the synchronous, active-low reset, sampled on the rising edge of clk_25mhz.
REQ-005 req_valid  in  NUM_REQ  SHALL carry per-requester "byte pending" flags, held until accepted.
REQ-006 req_data  in  8*NUM_REQ  SHALL carry per-requester bytes; requester i occupies bits [8i+7:8i].
REQ-007 req_ready  out  NUM_REQ  SHALL be a one-hot, one-cycle accept pulse to the granted requester.
REQ-008 tx_data  out  8  SHALL drive the transmitter's sending_data input.
REQ-009 tx_start  out  1  SHALL drive the transmitter's uart_tx_ready input.
REQ-010 tx_done  in  1  SHALL be the transmitter's uart_tx_done pulse (last data bit complete).
REQ-011 tx_tick  in  1  SHALL be the transmitter's uart_tick_out bit-period pulse.
REQ-012 busy  out  1  SHALL be high whenever state is not IDLE.
REQ-013 grant_id  out  $clog2(NUM_REQ)  SHALL hold the index of the current or most recent grant.
REQ-014 frames_sent  out  16  SHALL count completed frames.
REQ-015 timeout_err  out  1  SHALL be a sticky flag set on timeout abort.

Function
REQ-016 States SHALL be IDLE, LOAD, WAIT_DONE, WAIT_STOP.
REQ-017 IDLE: if any req_valid is high, the block SHALL pick the winner round-robin, searching from (last_grant+1) mod NUM_REQ upward with wrap.
REQ-018 In that same cycle it SHALL pulse req_ready[winner], latch req_data of the winner into the tx_data register, update grant_id and last_grant, and go to LOAD.
REQ-019 IDLE with no req_valid SHALL stay in IDLE with all req_ready low.
REQ-020 LOAD SHALL assert tx_start for exactly one cycle, clear the timeout counter and go to WAIT_DONE.
REQ-021 tx_start SHALL be low in every state except LOAD.
REQ-022 tx_data SHALL stay constant from the latch cycle until the state returns to IDLE.
REQ-023 WAIT_DONE: on tx_done the block SHALL go to WAIT_STOP; tx_tick alone SHALL be ignored.
REQ-024 WAIT_STOP: on the next tx_tick the block SHALL increment frames_sent (wrap 16'hFFFF -> 0) and return to IDLE.
REQ-025 A tx_tick coincident with the tx_done cycle SHALL NOT terminate WAIT_STOP, because it is consumed in WAIT_DONE.
REQ-026 The timeout counter SHALL increment every cycle in WAIT_DONE.
REQ-027 If the timeout counter reaches TIMEOUT before tx_done, the block SHALL set timeout_err and return to IDLE; frames_sent SHALL NOT increment.
REQ-028 Earliest next grant SHALL be the cycle in IDLE after the return, so a back-to-back accept is 1 cycle after frame end.
REQ-029 req_valid deasserted by a non-granted requester SHALL simply remove it from arbitration; there is no accept-side lock.
REQ-030 Grant to a requester whose req_valid is low SHALL never occur.
REQ-031 If only one requester is active, it SHALL be granted every frame.

Reset
REQ-032 With reset_n low at a clock edge: state=IDLE, req_ready=0, tx_start=0, tx_data=8'h00, grant_id=0, last_grant=NUM_REQ-1 (so requester 0 has first priority), frames_sent=0, timeout_err=0, timeout counter=0.
REQ-033 Reset in any state, including mid-frame, SHALL abort immediately with no further req_ready or tx_start pulse.

Verification
REQ-034 Single byte: req_valid=4'b0001, req_data[7:0]=8'hA5 -> req_ready=4'b0001 for 1 cycle, tx_start 1 cycle later, tx_data=8'hA5 held; after tx_done then tx_tick -> frames_sent=1, busy=0.
REQ-035 Fairness: all four valid with bytes 8'h10..8'h13 held continuously -> grant order 0,1,2,3,0; frames_sent=4 after four frames.
REQ-036 Sparse wrap: last_grant=3, req_valid=4'b0100 -> grant_id=2; then req_valid=4'b0101 -> grant_id=0 on the next grant.
REQ-037 Timeout: TIMEOUT=100, tx_done never pulsed -> return to IDLE after 100 WAIT_DONE cycles, timeout_err=1, frames_sent unchanged.
REQ-038 Coincident tick: tx_tick high in the tx_done cycle -> state stays in WAIT_STOP until the following tx_tick.
REQ-039 Mid-frame reset: reset_n low during WAIT_DONE -> all outputs at REQ-032 values the next cycle; the first post-reset grant goes to requester 0 when all are valid.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Byte-request and UART-transmitter handshake bundle for uart_tx_arbiter.
// The master modport is the arbiter's view; slave is the requesters plus transmitter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_start;
  logic                 tx_done;
  logic                 tx_tick;

  modport master (
    input  req_valid, req_data, tx_done, tx_tick,
    output req_ready, tx_data, tx_start
  );

  modport slave (
    output req_valid, req_data, tx_done, tx_tick,
    input  req_ready, tx_data, tx_start
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding bytes from NUM_REQ requesters into a single UART
// transmitter, with a per-frame timeout on the transmitter's done pulse.
module uart_tx_arbiter #(
  parameter int          NUM_REQ = 4,
  parameter logic [31:0] TIMEOUT = 32'd40000
) (
  input  logic                       clk_25mhz,
  input  logic                       reset_n,
  uart_tx_arbiter_if.master          bus,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic [15:0]                frames_sent,
  output logic                       timeout_err
);

  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_DONE,
    WAIT_STOP
  } state_t;

  state_t             state;
  logic [GW-1:0]      last_grant;
  logic [31:0]        tmo_cnt;
  logic [GW-1:0]      winner;
  logic [NUM_REQ-1:0] winner_onehot;
  logic               found;

  // Search starts one past the previous winner so every requester is served in turn.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves it unassigned,
    // which would otherwise infer a latch.
    found         = 1'b0;
    winner        = last_grant;
    winner_onehot = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!found && bus.req_valid[idx]) begin
        found  = 1'b1;
        winner = idx[GW-1:0];
      end
    end
    winner_onehot[winner] = 1'b1;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk_25mhz) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    if (!reset_n) begin
      state         <= IDLE;
      bus.req_ready <= '0;
      bus.tx_start  <= 1'b0;
      bus.tx_data   <= 8'h00;
      grant_id      <= '0;
      last_grant    <= GW'(NUM_REQ - 1);
      frames_sent   <= 16'h0000;
      timeout_err   <= 1'b0;
      tmo_cnt       <= 32'd0;
    end else begin
      bus.req_ready <= '0;
      bus.tx_start  <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            bus.req_ready <= winner_onehot;
            bus.tx_data   <= bus.req_data[{winner, 3'b000} +: 8];
            grant_id      <= winner;
            last_grant    <= winner;
            state         <= LOAD;
          end
        end
        LOAD: begin
          bus.tx_start <= 1'b1;
          tmo_cnt      <= 32'd0;
          state        <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // A tick in this state, even alongside tx_done, is not the stop-bit tick.
          if (bus.tx_done) begin
            state <= WAIT_STOP;
          end else if (tmo_cnt + 32'd1 >= TIMEOUT) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        WAIT_STOP: begin
          if (bus.tx_tick) begin
            frames_sent <= frames_sent + 16'd1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised bench for uart_tx_arbiter: a round-robin reference model predicts each
// grant, and a behavioural transmitter answers tx_start with tx_done / tx_tick.
module tb_uart_tx_arbiter;
  localparam int NUM_REQ = 4;
  localparam int TMO     = 100;

  logic        clk_25mhz = 1'b0;
  logic        reset_n   = 1'b0;
  logic        busy;
  logic [1:0]  grant_id;
  logic [15:0] frames_sent;
  logic        timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: who was served last, frames completed, sticky error.
  int model_last   = NUM_REQ - 1;
  int model_frames = 0;
  bit model_terr   = 1'b0;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ),
    .TIMEOUT(32'(TMO))
  ) dut (
    .clk_25mhz  (clk_25mhz),
    .reset_n    (reset_n),
    .bus        (bus),
    .busy       (busy),
    .grant_id   (grant_id),
    .frames_sent(frames_sent),
    .timeout_err(timeout_err)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [NUM_REQ-1:0] v);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (model_last + k) % NUM_REQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input bit v, input logic [7:0] d);
    bus.req_valid[i]       = v;
    bus.req_data[8*i +: 8] = d;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk_25mhz);
    reset_n      = 1'b1;
    model_last   = NUM_REQ - 1;
    model_frames = 0;
    model_terr   = 1'b0;
  endtask

  // Called at a negedge with the DUT in IDLE and at least one req_valid high.
  task automatic do_frame(input bit abort, input bit coinc, input bit reshuffle,
                          output int granted);
    int         exp_id;
    logic [7:0] exp_byte;
    int         waited;
    int         d;
    int         g;
    granted  = -1;
    exp_id   = rr_pick(bus.req_valid);
    exp_byte = bus.req_data[8*exp_id +: 8];
    waited   = 0;
    do begin
      @(negedge clk_25mhz);
      waited++;
    end while (bus.req_ready == '0 && waited < 10);
    check("grant_latency", waited, 1);
    if (bus.req_ready == '0) return;
    check("req_ready", bus.req_ready, 32'(1) << exp_id);
    check("grant_id", grant_id, exp_id);
    check("busy_load", busy, 1);
    check("tx_start_load", bus.tx_start, 0);
    model_last = exp_id;
    granted    = exp_id;
    if (reshuffle) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (i == exp_id || $urandom_range(0, 3) == 0)
          set_req(i, 1'($urandom_range(0, 1)), 8'($urandom));
    end
    @(negedge clk_25mhz);
    check("tx_start_pulse", bus.tx_start, 1);
    check("tx_data", bus.tx_data, exp_byte);
    check("req_ready_pulse", bus.req_ready, 0);
    d = abort ? TMO - 1 : int'($urandom_range(1, 20));
    for (int i = 1; i <= d; i++) begin
      @(negedge clk_25mhz);
      if (i == 1) check("tx_start_once", bus.tx_start, 0);
      bus.tx_tick = ($urandom_range(0, 3) == 0);
    end
    if (abort) begin
      check("busy_before_timeout", busy, 1);
      bus.tx_tick = 1'b0;
      @(negedge clk_25mhz);
      model_terr = 1'b1;
      check("busy_after_timeout", busy, 0);
      check("timeout_err", timeout_err, 1);
      check("frames_after_timeout", frames_sent, model_frames);
      return;
    end
    bus.tx_done = 1'b1;
    bus.tx_tick = coinc;
    @(negedge clk_25mhz);
    bus.tx_done = 1'b0;
    bus.tx_tick = 1'b0;
    g = int'($urandom_range(1, 4));
    repeat (g) @(negedge clk_25mhz);
    check("busy_wait_stop", busy, 1);
    check("frames_wait_stop", frames_sent, model_frames);
    check("tx_data_held", bus.tx_data, exp_byte);
    bus.tx_tick = 1'b1;
    @(negedge clk_25mhz);
    bus.tx_tick  = 1'b0;
    model_frames = (model_frames + 1) & 16'hFFFF;
    check("busy_frame_end", busy, 0);
    check("frames_sent", frames_sent, model_frames);
    check("timeout_err_state", timeout_err, model_terr);
  endtask

  initial begin
    int gr;
    int order[5] = '{0, 1, 2, 3, 0};
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.tx_done   = 1'b0;
    bus.tx_tick   = 1'b0;
    repeat (3) @(negedge clk_25mhz);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_tx_start", bus.tx_start, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_frames", frames_sent, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_busy", busy, 0);
    reset_n = 1'b1;

    // Idle with nothing pending
    repeat (4) begin
      @(negedge clk_25mhz);
      check("idle_ready", bus.req_ready, 0);
      check("idle_busy", busy, 0);
    end

    // Single byte
    set_req(0, 1'b1, 8'hA5);
    do_frame(1'b0, 1'b0, 1'b0, gr);
    set_req(0, 1'b0, 8'h00);
    check("single_grant", gr, 0);
    check("single_frames", frames_sent, 1);

    // Fairness with all four held
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 8'(8'h10 + i));
    for (int f = 0; f < 5; f++) begin
      do_frame(1'b0, 1'($urandom_range(0, 1)), 1'b0, gr);
      check("fair_order", gr, order[f]);
      if (f == 3) check("fair_frames4", frames_sent, 4);
    end

    // Sparse wrap: serve 3, then only 2 pending, then 0 and 2
    bus.req_valid = 4'b1000;
    do_frame(1'b0, 1'b0, 1'b0, gr);
    check("sparse_setup", gr, 3);
    bus.req_valid = 4'b0100;
    do_frame(1'b0, 1'b0, 1'b0, gr);
    check("sparse_grant2", gr, 2);
    bus.req_valid = 4'b0101;
    do_frame(1'b0, 1'b0, 1'b0, gr);
    check("sparse_grant0", gr, 0);

    // Coincident tick with tx_done
    bus.req_valid = 4'b0010;
    do_frame(1'b0, 1'b1, 1'b0, gr);
    check("coinc_grant", gr, 1);

    // Timeout abort
    bus.req_valid = 4'b0001;
    do_frame(1'b1, 1'b0, 1'b0, gr);
    bus.req_valid = 4'b0000;
    @(negedge clk_25mhz);
    check("timeout_idle_ready", bus.req_ready, 0);

    // Randomised traffic
    for (int f = 0; f < 40; f++) begin
      if (bus.req_valid == '0) set_req(int'($urandom_range(0, NUM_REQ - 1)), 1'b1, 8'($urandom));
      do_frame(1'($urandom_range(0, 14) == 0), 1'($urandom_range(0, 1)), 1'b1, gr);
    end
    check("terr_sticky", timeout_err, 1);

    // Mid-frame reset
    bus.req_valid = 4'b1111;
    @(negedge clk_25mhz);
    check("mid_grant_seen", (bus.req_ready != '0), 1);
    repeat (3) @(negedge clk_25mhz);
    reset_n = 1'b0;
    @(negedge clk_25mhz);
    check("mid_rst_ready", bus.req_ready, 0);
    check("mid_rst_tx_start", bus.tx_start, 0);
    check("mid_rst_tx_data", bus.tx_data, 0);
    check("mid_rst_grant_id", grant_id, 0);
    check("mid_rst_frames", frames_sent, 0);
    check("mid_rst_terr", timeout_err, 0);
    check("mid_rst_busy", busy, 0);
    repeat (3) begin
      @(negedge clk_25mhz);
      check("mid_rst_hold_ready", bus.req_ready, 0);
      check("mid_rst_hold_start", bus.tx_start, 0);
    end
    reset_n      = 1'b1;
    model_last   = NUM_REQ - 1;
    model_frames = 0;
    model_terr   = 1'b0;
    do_frame(1'b0, 1'b0, 1'b0, gr);
    check("post_rst_grant", gr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
